spi_init_seq: RTL
=================

SPI_INIT_SEQ -- requirements
Module: spi_init_seq

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 12, SPI command word width.
REQ-002 SHALL have parameter READ_WIDTH, default 8, SPI read-data width.
REQ-003 SHALL have parameter NUM_CMDS, default 16, number of table entries (2..256).
REQ-004 SHALL have parameter RD_TIMEOUT, default 1023, maximum cycles to wait for read data.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that launches the table sequence.
REQ-008 SHALL have port busy, output, 1 bit: high while the sequence runs.
REQ-009 SHALL have port done, output, 1 bit: sticky flag, sequence completed without error.
REQ-010 SHALL have port err, output, 1 bit: sticky flag, sequence aborted.
REQ-011 SHALL have port err_code, output, 2 bits: 01 = read mismatch, 10 = read timeout, 00 = none.
REQ-012 SHALL have port err_idx, output, 8 bits: table index of the failing entry.
REQ-013 SHALL have port cmd_out, output, CMD_WIDTH bits: command word to the SPI master.
REQ-014 SHALL have port cmd_vld, output, 1 bit: cmd_out is valid.
REQ-015 SHALL have port cmd_rdy, input, 1 bit: the SPI master accepts the command.
REQ-016 SHALL have port read_vld, input, 1 bit: single-cycle read-data strobe from the SPI master.
REQ-017 SHALL have port read_data, input, READ_WIDTH bits: read data from the SPI master.

Function
REQ-018 SHALL use the command format bit[11] = R/W (1 = read), bits[10:8] = address, bits[7:0] = write data (write) or expected data (read).
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_RD, NEXT, DONE and FAIL.
REQ-020 SHALL move from IDLE, DONE or FAIL to ISSUE on start, with index = 0 and done, err and err_code cleared, in the same edge.
REQ-021 SHALL assert cmd_vld in the first cycle after the start pulse.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL hold cmd_vld high and cmd_out stable in ISSUE until the cycle where cmd_vld and cmd_rdy are both high (the transfer).
REQ-024 SHALL deassert cmd_vld in the cycle after a transfer, and never raise cmd_vld outside ISSUE.
REQ-025 SHALL go on transfer from ISSUE to NEXT for a write entry, and to WAIT_RD for a read entry, loading the timeout counter with 0.
REQ-026 SHALL, in WAIT_RD on read_vld, compare read_data with the expected byte; on match go to NEXT, on mismatch go to FAIL with err_code 01 and err_idx = index.
REQ-027 SHALL increment the timeout counter every WAIT_RD cycle without read_vld; on reaching RD_TIMEOUT go to FAIL with err_code 10.
REQ-028 SHALL give read_vld priority over timeout when both occur in the same cycle.
REQ-029 SHALL ignore read_vld outside WAIT_RD.
REQ-030 SHALL, in NEXT, go to DONE if index = NUM_CMDS-1, else increment index and return to ISSUE, for one cycle of gap between commands.
REQ-031 SHALL, in DONE, set done = 1; in FAIL, set err = 1; both flags hold until the next start or reset.
REQ-032 SHALL drive busy = 1 exactly in ISSUE, WAIT_RD and NEXT.

Reset
REQ-033 SHALL on rst_n low force IDLE, index 0, timeout counter 0, cmd_vld 0, cmd_out 0, busy 0, done 0, err 0, err_code 00, err_idx 0, mid-transfer included.
REQ-034 SHALL not issue any command after reset release until a new start.

Structure
REQ-035 SHALL place the state encoding, command field positions and err_code values in a shared package.
REQ-036 SHALL put the command table in one sub-module, spi_init_rom: combinational index -> CMD_WIDTH word, NUM_CMDS entries.

Verification
REQ-037 SHALL cover a table of 3 writes with cmd_rdy tied high: start -> cmd_vld at cycles +1, +3, +5, then done = 1, busy = 0, err = 0.
REQ-038 SHALL cover cmd_rdy held low 10 cycles on entry 0 (0x0A5): cmd_out stays 0x0A5 with cmd_vld high for all 10 cycles, one transfer only.
REQ-039 SHALL cover read entry 0x83C returning read_data 0x3C: next entry is issued; returning 0x3D instead gives err = 1, err_code = 01, err_idx = that index.
REQ-040 SHALL cover a read with no read_vld and RD_TIMEOUT = 15: FAIL after 15 WAIT_RD cycles, err_code = 10; read_vld on cycle 15 gives a pass instead.
REQ-041 SHALL cover rst_n asserted during WAIT_RD: all outputs return to reset values; a later start replays from index 0.
REQ-042 SHALL cover start pulsed while busy and a stray read_vld in ISSUE: no effect on the sequence or the flags.

Source files
------------

// File: rtl/spi_init_seq_pkg.sv
// Shared definitions for the SPI init sequencer: FSM states, command-word field
// positions and error codes.
package spi_init_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    NEXT,
    DONE,
    FAIL
  } state_t;

  // Command word: [11] R/W (1 = read), [10:8] address, [7:0] write/expected data
  localparam int CMD_RW_BIT   = 11;
  localparam int CMD_ADDR_MSB = 10;
  localparam int CMD_ADDR_LSB = 8;
  localparam int CMD_DATA_MSB = 7;
  localparam int CMD_DATA_LSB = 0;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/spi_init_rom.sv
// Command table for the SPI init sequencer: combinational index -> command word.
// Indices at or beyond NUM_CMDS return zero.
module spi_init_rom #(
  parameter int CMD_WIDTH = 12,
  parameter int NUM_CMDS  = 16
) (
  input  logic [7:0]           idx,
  output logic [CMD_WIDTH-1:0] word
);

  logic [11:0] raw;

  // NOTE: the table is pure combinational decode with no storage, so there is nothing to reset.
  always_comb begin
    raw = '0;
    case (idx)
      8'd0:    raw = 12'h0A5;
      8'd1:    raw = 12'h112;
      8'd2:    raw = 12'h234;
      8'd3:    raw = 12'h83C;
      8'd4:    raw = 12'h356;
      8'd5:    raw = 12'h9C3;
      8'd6:    raw = 12'h478;
      8'd7:    raw = 12'h5E1;
      8'd8:    raw = 12'hA0F;
      8'd9:    raw = 12'h69A;
      8'd10:   raw = 12'h7FF;
      8'd11:   raw = 12'hB5A;
      8'd12:   raw = 12'h001;
      8'd13:   raw = 12'h180;
      8'd14:   raw = 12'hC77;
      8'd15:   raw = 12'h2C4;
      default: raw = {1'b0, 3'h7, idx};  // larger tables: filler writes to address 7
    endcase
    word = (int'(idx) < NUM_CMDS) ? CMD_WIDTH'(raw) : '0;
  end

endmodule

// File: rtl/spi_init_seq.sv
// SPI init sequencer: on start, walks the command table, hands each word to the
// SPI master, checks read-back data, and reports completion or the first failure.
module spi_init_seq
  import spi_init_seq_pkg::*;
#(
  parameter int CMD_WIDTH  = 12,
  parameter int READ_WIDTH = 8,
  parameter int NUM_CMDS   = 16,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [7:0]            err_idx,
  output logic [CMD_WIDTH-1:0]  cmd_out,
  output logic                  cmd_vld,
  input  logic                  cmd_rdy,
  input  logic                  read_vld,
  input  logic [READ_WIDTH-1:0] read_data
);

  localparam int              TW        = $clog2(RD_TIMEOUT + 1);
  localparam logic [7:0]      LAST_IDX  = 8'(NUM_CMDS - 1);
  localparam logic [TW-1:0]   TMO_LIMIT = TW'(RD_TIMEOUT);

  state_t                  state, state_nxt;
  logic [7:0]              idx, idx_nxt;
  logic [TW-1:0]           tmo_cnt, tmo_nxt, tmo_inc;
  logic [1:0]              err_code_nxt;
  logic [7:0]              err_idx_nxt;
  logic [CMD_WIDTH-1:0]    rom_word;
  logic                    is_read;
  logic [READ_WIDTH-1:0]   exp_data;

  spi_init_rom #(
    .CMD_WIDTH (CMD_WIDTH),
    .NUM_CMDS  (NUM_CMDS)
  ) u_rom (
    .idx  (idx),
    .word (rom_word)
  );

  assign is_read  = rom_word[CMD_RW_BIT];
  assign exp_data = READ_WIDTH'(rom_word[CMD_DATA_MSB:CMD_DATA_LSB]);
  assign tmo_inc  = tmo_cnt + TW'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      tmo_cnt  <= '0;
      err_code <= ERR_NONE;
      err_idx  <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      tmo_cnt  <= tmo_nxt;
      err_code <= err_code_nxt;
      err_idx  <= err_idx_nxt;
    end
  end

  // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    tmo_nxt      = tmo_cnt;
    err_code_nxt = err_code;
    err_idx_nxt  = err_idx;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_nxt    = ISSUE;
          idx_nxt      = '0;
          err_code_nxt = ERR_NONE;
        end
      end
      ISSUE: begin
        if (cmd_rdy) begin
          tmo_nxt   = '0;
          state_nxt = is_read ? WAIT_RD : NEXT;
        end
      end
      WAIT_RD: begin
        // A strobe in the final cycle still wins over the timeout
        if (read_vld) begin
          if (read_data == exp_data) begin
            state_nxt = NEXT;
          end else begin
            state_nxt    = FAIL;
            err_code_nxt = ERR_MISMATCH;
            err_idx_nxt  = idx;
          end
        end else begin
          tmo_nxt = tmo_inc;
          if (tmo_inc == TMO_LIMIT) begin
            state_nxt    = FAIL;
            err_code_nxt = ERR_TIMEOUT;
            err_idx_nxt  = idx;
          end
        end
      end
      NEXT: begin
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 8'd1;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from state only, so cmd_out is stable for the whole ISSUE window
  always_comb begin
    cmd_vld = (state == ISSUE);
    cmd_out = cmd_vld ? rom_word : '0;
    busy    = (state == ISSUE) || (state == WAIT_RD) || (state == NEXT);
    done    = (state == DONE);
    err     = (state == FAIL);
  end

endmodule
